// File: rtl/lfsr_index_decoder_pkg.sv
// Shared LFSR definitions: width, seed, decoder state encoding and the single
// step rule used by both the search LFSR and the index decoder.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'h8000;
    localparam int LFSR_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Operates on a zero-extended state so any width up to LFSR_MAX_WIDTH shares one rule.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_next(
        input logic [LFSR_MAX_WIDTH-1:0] s,
        input logic [LFSR_MAX_WIDTH-1:0] en,
        input int unsigned               w
    );
        logic [LFSR_MAX_WIDTH-1:0] fb;
        fb = {{(LFSR_MAX_WIDTH-1){1'b0}}, ^(s & en)};
        return (s >> 1) | (fb << (w - 1));
    endfunction

endpackage

// File: rtl/lfsr_index_decoder_if.sv
// Request/result bundle between a decode requester and lfsr_index_decoder.
interface lfsr_index_decoder_if
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH
);
    logic [WIDTH-1:0] En;
    logic [WIDTH-1:0] Target;
    logic             Start;
    logic             Busy;
    logic             Done;
    logic             Found;
    logic [15:0]      Index;

    modport master (output En, Target, Start, input Busy, Done, Found, Index);
    modport slave  (input En, Target, Start, output Busy, Done, Found, Index);
endinterface

// File: rtl/lfsr_index_decoder_step_core.sv
// Shadow LFSR register: loads the seed or advances one step per enabled cycle.
module lfsr_step_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] en,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] next_state;

    assign next_state = WIDTH'(lfsr_next(LFSR_MAX_WIDTH'(state), LFSR_MAX_WIDTH'(en), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/lfsr_index_decoder.sv
// Converts an LFSR state into its step index from SEED by replaying a shadow LFSR.
//   state  | meaning
//   IDLE   | waiting for Start
//   SEARCH | one compare per cycle, shadow/count advance on miss
//   DONE   | single cycle, Done high, Start accepted here too
module lfsr_index_decoder
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(LFSR_SEED),
    parameter int               MAX_STEPS = 65535
) (
    input  logic                 LFSR_Clock,
    input  logic                 Reset,
    lfsr_index_decoder_if.slave  bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] shadow;
    logic [15:0]      count;
    logic [15:0]      index_q;
    logic             found_q;
    logic             accept;
    logic             zero_tgt;
    logic             hit;
    logic             last;
    logic             finish;

    assign accept   = bus.Start && (state != SEARCH);
    assign zero_tgt = (target_q == '0);
    assign hit      = (shadow == target_q);
    assign last     = (count == 16'(MAX_STEPS - 1));
    assign finish   = (state == SEARCH) && (zero_tgt || hit || last);

    always_ff @(posedge LFSR_Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = SEARCH;
            SEARCH:  if (finish) state_next = DONE;
            DONE:    state_next = bus.Start ? SEARCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        case (state)
            SEARCH:  bus.Busy = 1'b1;
            DONE:    bus.Done = 1'b1;
            default: ;
        endcase
    end

    // Compare priority: zero target, then match, then bound; first match gives the smallest index.
    always_ff @(posedge LFSR_Clock) begin
        if (Reset) begin
            target_q <= '0;
            en_q     <= '0;
            count    <= '0;
            found_q  <= 1'b0;
            index_q  <= '0;
        end else if (accept) begin
            target_q <= bus.Target;
            en_q     <= bus.En;
            count    <= '0;
            found_q  <= 1'b0;
            index_q  <= '0;
        end else if (state == SEARCH) begin
            if (zero_tgt) begin
                found_q <= 1'b0;
                index_q <= 16'(MAX_STEPS);
            end else if (hit) begin
                found_q <= 1'b1;
                index_q <= count;
            end else if (last) begin
                found_q <= 1'b0;
                index_q <= 16'(MAX_STEPS);
            end else begin
                count <= count + 16'd1;
            end
        end
    end

    lfsr_step_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk   (LFSR_Clock),
        .rst   (Reset),
        .load  (accept),
        .step  ((state == SEARCH) && !finish),
        .en    (en_q),
        .state (shadow)
    );

    assign bus.Found = found_q;
    assign bus.Index = index_q;

endmodule
